// File: rtl/frame_fifo_writer_pkg.sv
// Shared definitions for the frame FIFO writer: input data-type codes and the
// footer word layout that host software decodes.
package frame_fifo_writer_pkg;

  localparam int DTYPE_WIDTH = 8;

  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START = 8'h01;
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = 8'h02;
  localparam logic [DTYPE_WIDTH-1:0] DT_HEADER      = 8'h04;
  localparam logic [DTYPE_WIDTH-1:0] DT_STATUS      = 8'h08;
  // Any dtype with a bit set here is a pixel word (YUV planes, raw, ...).
  localparam logic [DTYPE_WIDTH-1:0] PIXEL_MASK     = 8'hF0;

  localparam int TRUNC_BIT   = 31;
  localparam int UNTERM_BIT  = 30;
  localparam int COUNT_WIDTH = 24;

  function automatic logic [31:0] make_footer(input logic                   trunc,
                                              input logic                   unterm,
                                              input logic [COUNT_WIDTH-1:0] count);
    logic [31:0] word;
    word                    = '0;
    word[TRUNC_BIT]         = trunc;
    word[UNTERM_BIT]        = unterm;
    word[COUNT_WIDTH-1:0]   = count;
    return word;
  endfunction

endpackage

// File: rtl/frame_fifo_writer.sv
// Writes packed header/pixel words of admitted frames into the host FIFO and
// closes every admitted frame with a footer {trunc, unterm, 6'b0, word_count}.
module frame_fifo_writer
  import frame_fifo_writer_pkg::*;
#(
  parameter int FIFO_ADDR_WIDTH = 11,
  parameter int MIN_FREE_WORDS  = 512
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       enable,
  input  logic                       dvi,
  input  logic [DTYPE_WIDTH-1:0]     dtypei,
  input  logic [31:0]                datai,
  input  logic [FIFO_ADDR_WIDTH:0]   fifo_free,
  output logic                       fifo_we,
  output logic [31:0]                fifo_data,
  output logic [15:0]                frame_count,
  output logic [15:0]                drop_count,
  output logic                       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_TRUNC,
    ST_FOOTER,
    ST_DROP
  } state_e;

  localparam logic [FIFO_ADDR_WIDTH:0] MIN_FREE     = (FIFO_ADDR_WIDTH+1)'(MIN_FREE_WORDS);
  // fifo_free lags fifo_we by a cycle, so one in-flight write must still fit.
  localparam logic [FIFO_ADDR_WIDTH:0] WRITE_MARGIN = (FIFO_ADDR_WIDTH+1)'(2);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
  logic                   trunc_q, trunc_d;
  logic                   unterm_q, unterm_d;
  logic                   drop_pending_q, drop_pending_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [15:0]            drop_count_q, drop_count_d;
  logic                   fifo_we_q, fifo_we_d;
  logic [31:0]            fifo_data_q, fifo_data_d;
  logic                   busy_q;

  logic frame_start;
  logic frame_end;
  logic payload;
  logic can_write;
  logic footer_req;
  logic drop_inc;

  assign frame_start = dvi && (dtypei == DT_FRAME_START);
  assign frame_end   = dvi && (dtypei == DT_FRAME_END);
  assign payload     = dvi && ((dtypei == DT_HEADER) || (|(dtypei & PIXEL_MASK)));
  assign can_write   = (fifo_free >= WRITE_MARGIN);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    word_count_d   = word_count_q;
    trunc_d        = trunc_q;
    unterm_d       = unterm_q;
    drop_pending_d = drop_pending_q;
    frame_count_d  = frame_count_q;
    drop_count_d   = drop_count_q;
    fifo_we_d      = 1'b0;
    fifo_data_d    = fifo_data_q;
    footer_req     = 1'b0;
    drop_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          if (enable && (fifo_free >= MIN_FREE)) begin
            state_d        = ST_ACTIVE;
            word_count_d   = '0;
            trunc_d        = 1'b0;
            unterm_d       = 1'b0;
            drop_pending_d = 1'b0;
          end else begin
            state_d  = ST_DROP;
            drop_inc = 1'b1;
          end
        end
      end

      ST_ACTIVE, ST_TRUNC: begin
        if (frame_end || frame_start) begin
          footer_req = 1'b1;
          // An unterminated frame is closed here; the frame just starting is dropped.
          if (frame_start) begin
            unterm_d       = 1'b1;
            drop_pending_d = 1'b1;
            drop_inc       = 1'b1;
          end
        end else if (payload && (state_q == ST_ACTIVE)) begin
          if (can_write) begin
            fifo_we_d   = 1'b1;
            fifo_data_d = datai;
            if (word_count_q != '1) begin
              word_count_d = word_count_q + 24'd1;
            end
          end else begin
            trunc_d = 1'b1;
            state_d = ST_TRUNC;
          end
        end
      end

      ST_FOOTER: begin
        footer_req = 1'b1;
        if (frame_start) begin
          drop_pending_d = 1'b1;
          drop_inc       = 1'b1;
        end
      end

      ST_DROP: begin
        if (frame_end) begin
          state_d = ST_IDLE;
        end else if (frame_start) begin
          drop_inc = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Footer uses the flag values updated this cycle, so an unterm close
    // carries its own flag.
    if (footer_req) begin
      if (can_write) begin
        fifo_we_d      = 1'b1;
        fifo_data_d    = make_footer(trunc_d, unterm_d, word_count_d);
        frame_count_d  = frame_count_q + 16'd1;
        state_d        = drop_pending_d ? ST_DROP : ST_IDLE;
        drop_pending_d = 1'b0;
      end else begin
        state_d = ST_FOOTER;
      end
    end

    if (drop_inc && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q        <= ST_IDLE;
      word_count_q   <= '0;
      trunc_q        <= 1'b0;
      unterm_q       <= 1'b0;
      drop_pending_q <= 1'b0;
      frame_count_q  <= '0;
      drop_count_q   <= '0;
      fifo_we_q      <= 1'b0;
      fifo_data_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_count_q   <= word_count_d;
      trunc_q        <= trunc_d;
      unterm_q       <= unterm_d;
      drop_pending_q <= drop_pending_d;
      frame_count_q  <= frame_count_d;
      drop_count_q   <= drop_count_d;
      fifo_we_q      <= fifo_we_d;
      fifo_data_q    <= fifo_data_d;
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign fifo_we     = fifo_we_q;
  assign fifo_data   = fifo_data_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign busy        = busy_q;

endmodule
